// File: rtl/alarm_clock.sv
// 24-hour BCD clock (HH:MM:SS) with a single HH:MM alarm that latches when the
// running time reaches HH:MM:00 while enabled. One-second tick from a clk prescaler.
module alarm_clock #(
    parameter int CLK_PER_SEC = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] H_in1,
    input  logic [3:0] H_in0,
    input  logic [2:0] M_in1,
    input  logic [3:0] M_in0,
    input  logic       LD_time,
    input  logic       LD_alarm,
    input  logic       STOP_al,
    input  logic       AL_ON,
    output logic       Alarm,
    output logic [1:0] H_out1,
    output logic [3:0] H_out0,
    output logic [2:0] M_out1,
    output logic [3:0] M_out0,
    output logic [2:0] S_out1,
    output logic [3:0] S_out0
);

    localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
    localparam logic [PW-1:0] PMAX = PW'(CLK_PER_SEC - 1);

    logic [1:0]    h1_q, h1_d, ah1_q, ah1_d;
    logic [3:0]    h0_q, h0_d, ah0_q, ah0_d;
    logic [2:0]    m1_q, m1_d, am1_q, am1_d;
    logic [3:0]    m0_q, m0_d, am0_q, am0_d;
    logic [2:0]    s1_q, s1_d;
    logic [3:0]    s0_q, s0_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          alarm_q, alarm_d;

    logic ld_ok, tick, match;

    always_comb begin
        h1_d    = h1_q;
        h0_d    = h0_q;
        m1_d    = m1_q;
        m0_d    = m0_q;
        s1_d    = s1_q;
        s0_d    = s0_q;
        ah1_d   = ah1_q;
        ah0_d   = ah0_q;
        am1_d   = am1_q;
        am0_d   = am0_q;
        presc_d = presc_q;
        alarm_d = alarm_q;

        // A load with any out-of-range digit is dropped as if it never happened
        ld_ok = (H_in0 <= 4'd9) && (M_in0 <= 4'd9) && (M_in1 <= 3'd5) &&
                ((H_in1 < 2'd2) || ((H_in1 == 2'd2) && (H_in0 <= 4'd3)));
        tick  = (presc_q == PMAX);
        match = AL_ON && (h1_q == ah1_q) && (h0_q == ah0_q) &&
                (m1_q == am1_q) && (m0_q == am0_q) &&
                (s1_q == 3'd0) && (s0_q == 4'd0);

        if (LD_time && ld_ok) begin
            h1_d    = H_in1;
            h0_d    = H_in0;
            m1_d    = M_in1;
            m0_d    = M_in0;
            s1_d    = 3'd0;
            s0_d    = 4'd0;
            presc_d = '0;
        end else begin
            presc_d = tick ? '0 : presc_q + PW'(1);
            if (tick) begin
                if (s0_q != 4'd9) s0_d = s0_q + 4'd1;
                else begin
                    s0_d = 4'd0;
                    if (s1_q != 3'd5) s1_d = s1_q + 3'd1;
                    else begin
                        s1_d = 3'd0;
                        if (m0_q != 4'd9) m0_d = m0_q + 4'd1;
                        else begin
                            m0_d = 4'd0;
                            if (m1_q != 3'd5) m1_d = m1_q + 3'd1;
                            else begin
                                m1_d = 3'd0;
                                if ((h1_q == 2'd2) && (h0_q == 4'd3)) begin
                                    h1_d = 2'd0;
                                    h0_d = 4'd0;
                                end else if (h0_q == 4'd9) begin
                                    h0_d = 4'd0;
                                    h1_d = h1_q + 2'd1;
                                end else begin
                                    h0_d = h0_q + 4'd1;
                                end
                            end
                        end
                    end
                end
            end
        end

        if (LD_alarm && ld_ok) begin
            ah1_d = H_in1;
            ah0_d = H_in0;
            am1_d = M_in1;
            am0_d = M_in0;
        end

        // Silencing wins over a set condition on the same edge
        if (match) alarm_d = 1'b1;
        if (STOP_al || !AL_ON) alarm_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h1_q    <= '0;
            h0_q    <= '0;
            m1_q    <= '0;
            m0_q    <= '0;
            s1_q    <= '0;
            s0_q    <= '0;
            ah1_q   <= '0;
            ah0_q   <= '0;
            am1_q   <= '0;
            am0_q   <= '0;
            presc_q <= '0;
            alarm_q <= 1'b0;
        end else begin
            h1_q    <= h1_d;
            h0_q    <= h0_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            ah1_q   <= ah1_d;
            ah0_q   <= ah0_d;
            am1_q   <= am1_d;
            am0_q   <= am0_d;
            presc_q <= presc_d;
            alarm_q <= alarm_d;
        end
    end

    assign Alarm  = alarm_q;
    assign H_out1 = h1_q;
    assign H_out0 = h0_q;
    assign M_out1 = m1_q;
    assign M_out0 = m0_q;
    assign S_out1 = s1_q;
    assign S_out0 = s0_q;

endmodule

// File: tb/tb_alarm_clock.sv
// Scoreboard bench for alarm_clock: two instances (1 and 10 clk/s) share stimulus and
// are checked against a seconds-of-day reference model.
module tb_alarm_clock;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time, LD_alarm, STOP_al, AL_ON;

    logic       al_a, al_b;
    logic [1:0] h1_a, h1_b;
    logic [3:0] h0_a, h0_b, m0_a, m0_b, s0_a, s0_b;
    logic [2:0] m1_a, m1_b, s1_a, s1_b;

    alarm_clock #(.CLK_PER_SEC(1)) u_a (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
        .Alarm(al_a), .H_out1(h1_a), .H_out0(h0_a), .M_out1(m1_a), .M_out0(m0_a),
        .S_out1(s1_a), .S_out0(s0_a));

    alarm_clock #(.CLK_PER_SEC(10)) u_b (
        .clk(clk), .reset(reset), .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
        .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al), .AL_ON(AL_ON),
        .Alarm(al_b), .H_out1(h1_b), .H_out0(h0_b), .M_out1(m1_b), .M_out0(m0_b),
        .S_out1(s1_b), .S_out0(s0_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [20:0] ea;
        logic [20:0] eb;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: time as seconds of day, alarm as minutes of day
    int cps  [2] = '{1, 10};
    int tsec [2];
    int amin [2];
    int presc[2];
    bit al   [2];

    function automatic logic [20:0] enc(input int t, input bit a);
        int hh, mm, ss;
        hh = t / 3600;
        mm = (t / 60) % 60;
        ss = t % 60;
        return {a, 2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_step();
        int hv, mv;
        bit valid, match;
        hv    = int'(H_in1) * 10 + int'(H_in0);
        mv    = int'(M_in1) * 10 + int'(M_in0);
        valid = (hv < 24) && (H_in0 < 10) && (M_in1 < 6) && (M_in0 < 10);
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                tsec[i] = 0; amin[i] = 0; presc[i] = 0; al[i] = 1'b0;
            end else begin
                match = AL_ON && (tsec[i] == amin[i] * 60);
                if (LD_time && valid) begin
                    tsec[i]  = hv * 3600 + mv * 60;
                    presc[i] = 0;
                end else if (presc[i] == cps[i] - 1) begin
                    presc[i] = 0;
                    tsec[i]  = (tsec[i] + 1) % 86400;
                end else begin
                    presc[i] = presc[i] + 1;
                end
                if (LD_alarm && valid) amin[i] = hv * 60 + mv;
                if (STOP_al || !AL_ON) al[i] = 1'b0;
                else if (match)        al[i] = 1'b1;
            end
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge
    task automatic step();
        exp_t e;
        model_step();
        e.ea = enc(tsec[0], al[0]);
        e.eb = enc(tsec[1], al[1]);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        LD_time  = 1'b0;
        LD_alarm = 1'b0;
        STOP_al  = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_hm(input int hh, input int mm);
        H_in1 = 2'(hh / 10);
        H_in0 = 4'(hh % 10);
        M_in1 = 3'(mm / 10);
        M_in0 = 4'(mm % 10);
    endtask

    task automatic load(input int hh, input int mm, input bit t, input bit a);
        set_hm(hh, mm);
        LD_time  = t;
        LD_alarm = a;
        step();
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_cmp++;
            if ({al_a, h1_a, h0_a, m1_a, m0_a, s1_a, s0_a} !== e.ea) begin
                n_bad++;
                $display("FAIL cps1 t=%0t got=%h want=%h", $time,
                         {al_a, h1_a, h0_a, m1_a, m0_a, s1_a, s0_a}, e.ea);
            end
            n_cmp++;
            if ({al_b, h1_b, h0_b, m1_b, m0_b, s1_b, s0_b} !== e.eb) begin
                n_bad++;
                $display("FAIL cps10 t=%0t got=%h want=%h", $time,
                         {al_b, h1_b, h0_b, m1_b, m0_b, s1_b, s0_b}, e.eb);
            end
        end
    end

    initial begin
        int k;
        reset = 1'b0; AL_ON = 1'b0; STOP_al = 1'b0; LD_time = 1'b0; LD_alarm = 1'b0;
        set_hm(0, 0);
        @(negedge clk);
        run(2);
        reset = 1'b1;
        run(25);

        // alarm at 05:00 reached from 04:59:00, then silenced
        AL_ON = 1'b1;
        load(5, 0, 1'b0, 1'b1);
        load(4, 59, 1'b1, 1'b0);
        run(72);
        STOP_al = 1'b1;
        step();
        run(5);

        // disabled alarm never fires
        AL_ON = 1'b0;
        load(4, 59, 1'b1, 1'b0);
        run(70);

        // enabled then dropped while latched
        AL_ON = 1'b1;
        load(4, 59, 1'b1, 1'b0);
        run(65);
        AL_ON = 1'b0;
        run(3);
        AL_ON = 1'b1;

        // day rollover, then illegal loads
        load(23, 59, 1'b1, 1'b0);
        run(62);
        H_in1 = 2'd2; H_in0 = 4'd4; M_in1 = 3'd0; M_in0 = 4'd0;
        LD_time = 1'b1; LD_alarm = 1'b1;
        step();
        H_in1 = 2'd1; H_in0 = 4'd0; M_in1 = 3'd6; M_in0 = 4'd0;
        LD_time = 1'b1;
        step();
        H_in1 = 2'd0; H_in0 = 4'd12; M_in1 = 3'd1; M_in0 = 4'd0;
        LD_time = 1'b1;
        step();
        run(3);

        // randomized traffic with occasional near-future alarms and resets
        for (int i = 0; i < 2500; i++) begin
            k = int'($urandom_range(0, 99));
            if (k < 3) begin
                H_in1 = 2'($urandom); H_in0 = 4'($urandom);
                M_in1 = 3'($urandom); M_in0 = 4'($urandom);
                LD_time = 1'b1;
            end else if (k < 6) begin
                set_hm(int'($urandom_range(0, 23)), int'($urandom_range(0, 59)));
                LD_time  = 1'b1;
                LD_alarm = ($urandom_range(0, 1) == 1);
            end else if (k < 9) begin
                k = (tsec[0] / 60 + 1) % 1440;
                set_hm(k / 60, k % 60);
                LD_alarm = 1'b1;
            end else if (k < 11) begin
                STOP_al = 1'b1;
            end else if (k == 11) begin
                AL_ON = ~AL_ON;
            end else if (k == 12 && $urandom_range(0, 9) == 0) begin
                reset = 1'b0;
            end
            step();
            reset = 1'b1;
        end

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
